// File: rtl/seq_shift_unit.sv
// Iterative one-bit-per-clock shifter (SLL/SRL/SRA) for the execute stage.
// Presents the result and last shifted-out bit, with a one-cycle carry load enable.
module seq_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               carry_out,
    output logic               carry_we
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   sh_reg, sh_nx;
    logic [SHAMT_W-1:0] cnt, cnt_nx;
    logic [1:0]         op_reg, op_nx;
    logic               c_reg, c_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            sh_reg <= '0;
            cnt    <= '0;
            op_reg <= '0;
            c_reg  <= 1'b0;
        end else begin
            state  <= state_nx;
            sh_reg <= sh_nx;
            cnt    <= cnt_nx;
            op_reg <= op_nx;
            c_reg  <= c_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sh_nx    = sh_reg;
        cnt_nx   = cnt;
        op_nx    = op_reg;
        c_nx     = c_reg;
        case (state)
            S_SHIFT: begin
                case (op_reg)
                    OP_SLL: begin
                        c_nx  = sh_reg[WIDTH-1];
                        sh_nx = {sh_reg[WIDTH-2:0], 1'b0};
                    end
                    OP_SRL: begin
                        c_nx  = sh_reg[0];
                        sh_nx = {1'b0, sh_reg[WIDTH-1:1]};
                    end
                    OP_SRA: begin
                        c_nx  = sh_reg[0];
                        sh_nx = {sh_reg[WIDTH-1], sh_reg[WIDTH-1:1]};
                    end
                    default: begin
                        c_nx  = c_reg;
                        sh_nx = sh_reg;
                    end
                endcase
                cnt_nx = cnt - 1'b1;
                if (cnt == SHAMT_W'(1)) state_nx = S_DONE;
            end
            // IDLE and DONE both accept a new request; start during SHIFT is ignored.
            default: begin
                if (start) begin
                    sh_nx = a;
                    op_nx = op;
                    c_nx  = 1'b0;
                    if (shamt == '0 || op == OP_RSV) begin
                        state_nx = S_DONE;
                    end else begin
                        cnt_nx   = shamt;
                        state_nx = S_SHIFT;
                    end
                end else begin
                    state_nx = S_IDLE;
                end
            end
        endcase
    end

    assign result    = sh_reg;
    assign carry_out = c_reg;
    assign busy      = (state == S_SHIFT);
    assign done      = (state == S_DONE);
    assign carry_we  = (state == S_DONE);

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed self-checking bench for seq_shift_unit: latency, results, carry,
// hold behaviour, ignored start while busy, back-to-back requests and reset.
module tb_seq_shift_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        carry_out;
    logic        carry_we;

    int n_checks = 0;
    int n_errors = 0;

    seq_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .shamt     (shamt),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .carry_we  (carry_we)
    );

    // clock: inputs change and outputs are sampled on the falling edge
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue a request at the current falling edge (cycle 0) and wait for done.
    // Leaves the bench at the falling edge of the DONE cycle.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                          input logic [4:0] sa, input logic [31:0] exp_res,
                          input logic exp_c, input int exp_lat);
        int   k;
        logic busy_ok;
        start = 1'b1; op = o; a = av; shamt = sa;
        k = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            start = 1'b0;
            k++;
            if (!done && !busy) busy_ok = 1'b0;
        end while (!done && k < 100);
        check({tag, " latency"}, k, exp_lat);
        check({tag, " busy_during"}, {31'b0, busy_ok}, 32'd1);
        check({tag, " result"}, result, exp_res);
        check({tag, " carry_out"}, {31'b0, carry_out}, {31'b0, exp_c});
        check({tag, " carry_we"}, {31'b0, carry_we}, 32'd1);
        check({tag, " busy_at_done"}, {31'b0, busy}, 32'd0);
    endtask

    // One idle cycle after DONE: pulse ends, result and carry held.
    task automatic check_hold(input string tag, input logic [31:0] exp_res, input logic exp_c);
        start = 1'b0;
        @(negedge clk);
        check({tag, " done_pulse"}, {31'b0, done}, 32'd0);
        check({tag, " we_pulse"}, {31'b0, carry_we}, 32'd0);
        check({tag, " hold_result"}, result, exp_res);
        check({tag, " hold_carry"}, {31'b0, carry_out}, {31'b0, exp_c});
    endtask

    initial begin
        int k;
        int done_seen;

        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; shamt = '0;
        repeat (2) @(negedge clk);
        check("reset result", result, 32'h0);
        check("reset flags", {27'b0, busy, done, carry_we, carry_out, 1'b0}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // main functions
        run_op("sll1", 2'b00, 32'h8000_0001, 5'd1, 32'h0000_0002, 1'b1, 2);
        check_hold("sll1", 32'h0000_0002, 1'b1);
        run_op("sra5", 2'b10, 32'hF000_0010, 5'd5, 32'hFF80_0000, 1'b1, 6);
        check_hold("sra5", 32'hFF80_0000, 1'b1);
        run_op("srl5", 2'b01, 32'hF000_0010, 5'd5, 32'h0780_0000, 1'b1, 6);
        check_hold("srl5", 32'h0780_0000, 1'b1);
        run_op("sh0", 2'b00, 32'h1234_5678, 5'd0, 32'h1234_5678, 1'b0, 1);
        check_hold("sh0", 32'h1234_5678, 1'b0);
        run_op("rsv", 2'b11, 32'h1234_5678, 5'd7, 32'h1234_5678, 1'b0, 1);
        check_hold("rsv", 32'h1234_5678, 1'b0);
        run_op("sra31", 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 32);
        run_op("srl31", 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 32);
        check_hold("srl31", 32'h0000_0001, 1'b0);

        // start pulses while busy are ignored
        start = 1'b1; op = 2'b00; a = 32'h1; shamt = 5'd31;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k >= 3 && k <= 10) begin
                start = 1'b1; op = 2'b01; a = $urandom; shamt = 5'($urandom_range(1, 31));
            end else begin
                start = 1'b0;
            end
        end while (!done && k < 100);
        check("busy_ign latency", k, 32);
        check("busy_ign result", result, 32'h8000_0000);
        check("busy_ign carry", {31'b0, carry_out}, 32'd0);
        // back-to-back: start on the DONE cycle
        run_op("b2b", 2'b01, 32'h0000_0003, 5'd2, 32'h0, 1'b1, 3);
        check_hold("b2b", 32'h0, 1'b1);

        // reset during a shift
        start = 1'b1; op = 2'b00; a = 32'hFFFF_FFFF; shamt = 5'd10;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid result", result, 32'h0);
        check("rst_mid flags", {27'b0, busy, done, carry_we, carry_out, 1'b0}, 32'h0);
        done_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || carry_we || busy) done_seen++;
        end
        check("rst_mid no_done", done_seen, 0);
        run_op("post_rst", 2'b10, 32'h8000_00F0, 5'd4, 32'hF800_000F, 1'b0, 5);
        check_hold("post_rst", 32'hF800_000F, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
